// File: rtl/ram_scan_reader.sv
`default_nettype none
// ============================================================================
// Module      : ram_scan_reader
// Description : Walks an address range of a synchronous-read RAM and streams
//               each (address, word) pair out on a valid/ready interface.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_scan_reader #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 3,
  parameter int DWELL_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  continuous,
  input  logic                  stop,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] c_dwell_last =
    CNT_W'((DWELL_CYCLES > 0) ? DWELL_CYCLES - 1 : 0);
  localparam bit c_has_dwell = (DWELL_CYCLES > 0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_PRESENT = 3'd3,
    S_DWELL   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic [ADDR_WIDTH-1:0] r_cur_addr;
  logic [ADDR_WIDTH-1:0] r_start_addr;
  logic [ADDR_WIDTH-1:0] r_end_addr;
  logic                  r_continuous;
  logic                  r_stop_pending;
  logic [CNT_W-1:0]      r_dwell_cnt;
  logic [ADDR_WIDTH-1:0] r_ram_address;
  logic [ADDR_WIDTH-1:0] r_out_addr;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  r_done;

  logic                  w_load;
  logic                  w_capture;
  logic                  w_handshake;
  logic                  w_advance;
  logic                  w_to_issue;
  logic                  w_finish;
  logic [ADDR_WIDTH-1:0] w_next_addr;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and control decode
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_capture    = 1'b0;
    w_handshake  = 1'b0;
    w_advance    = 1'b0;
    w_to_issue   = 1'b0;
    w_finish     = 1'b0;
    w_next_addr  = r_cur_addr;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_next_state = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_capture    = 1'b1;
        w_next_state = S_PRESENT;
      end
      S_PRESENT: begin
        if (out_ready) begin
          w_handshake = 1'b1;
          if (c_has_dwell) begin
            w_next_state = S_DWELL;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      S_DWELL: begin
        if (r_dwell_cnt == c_dwell_last) begin
          w_advance = 1'b1;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase

    // A pending stop wins over both the range step and the continuous wrap.
    if (w_advance) begin
      if (r_stop_pending) begin
        w_finish     = 1'b1;
        w_next_state = S_IDLE;
      end else if (r_cur_addr != r_end_addr) begin
        w_to_issue   = 1'b1;
        w_next_addr  = r_cur_addr + 1'b1;
        w_next_state = S_ISSUE;
      end else if (r_continuous) begin
        w_to_issue   = 1'b1;
        w_next_addr  = r_start_addr;
        w_next_state = S_ISSUE;
      end else begin
        w_finish     = 1'b1;
        w_next_state = S_IDLE;
      end
    end
  end

  // Scan range, address and stop bookkeeping
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cur_addr     <= '0;
      r_start_addr   <= '0;
      r_end_addr     <= '0;
      r_continuous   <= 1'b0;
      r_ram_address  <= '0;
      r_stop_pending <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_done <= w_finish;

      if (w_load) begin
        r_start_addr  <= start_addr;
        r_end_addr    <= end_addr;
        r_continuous  <= continuous;
        r_cur_addr    <= start_addr;
        r_ram_address <= start_addr;
      end else if (w_to_issue) begin
        r_cur_addr    <= w_next_addr;
        r_ram_address <= w_next_addr;
      end

      if (w_load) begin
        r_stop_pending <= 1'b0;
      end else if ((r_state != S_IDLE) && stop) begin
        r_stop_pending <= 1'b1;
      end
    end
  end

  // Output stream register and dwell counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_addr  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_dwell_cnt <= '0;
    end else begin
      if (w_capture) begin
        r_out_data  <= ram_q;
        r_out_addr  <= r_cur_addr;
        r_out_valid <= 1'b1;
      end else if (w_handshake) begin
        r_out_valid <= 1'b0;
      end

      if (w_handshake || w_advance) begin
        r_dwell_cnt <= '0;
      end else if (r_state == S_DWELL) begin
        r_dwell_cnt <= r_dwell_cnt + 1'b1;
      end
    end
  end

  assign ram_address = r_ram_address;
  assign ram_wren    = 1'b0;
  assign out_addr    = r_out_addr;
  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ram_scan_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_scan_reader
// Description : Self-checking bench; two readers (dwell 0 and dwell 4) on
//               bench-owned RAM models, checked against a range-walk model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_scan_reader;

  localparam int AW = 5;
  localparam int DW = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                 reset_n;
  logic [1:0]           start, continuous, stop, out_ready;
  logic [1:0][AW-1:0]   start_addr, end_addr, ram_address, out_addr;
  logic [1:0]           ram_wren, out_valid, busy, done;
  logic [1:0][DW-1:0]   ram_q, out_data;
  logic [DW-1:0]        mem [32];

  int checks = 0;
  int errors = 0;

  ram_scan_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DWELL_CYCLES(0)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .start(start[0]), .continuous(continuous[0]),
    .stop(stop[0]), .start_addr(start_addr[0]), .end_addr(end_addr[0]),
    .ram_address(ram_address[0]), .ram_wren(ram_wren[0]), .ram_q(ram_q[0]),
    .out_addr(out_addr[0]), .out_data(out_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .busy(busy[0]), .done(done[0]));

  ram_scan_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DWELL_CYCLES(4)) u_dut4 (
    .clock(clock), .reset_n(reset_n), .start(start[1]), .continuous(continuous[1]),
    .stop(stop[1]), .start_addr(start_addr[1]), .end_addr(end_addr[1]),
    .ram_address(ram_address[1]), .ram_wren(ram_wren[1]), .ram_q(ram_q[1]),
    .out_addr(out_addr[1]), .out_data(out_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .busy(busy[1]), .done(done[1]));

  // Registered-read RAM models, one read port per reader
  always @(posedge clock) begin
    ram_q[0] <= mem[ram_address[0]];
    ram_q[1] <= mem[ram_address[1]];
  end

  function automatic int dwell_of(input int d);
    return (d == 0) ? 0 : 4;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = '0; continuous = '0; stop = '0; out_ready = '0;
    start_addr = '0; end_addr = '0;
    #12;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({out_valid[d], busy[d], done[d], ram_wren[d], ram_address[d], out_addr[d], out_data[d]} !== '0) begin
        errors++;
        $display("FAIL reset_state dut%0d: valid=%b busy=%b done=%b wren=%b addr=%0d oaddr=%0d odata=%0d, want all 0",
                 d, out_valid[d], busy[d], done[d], ram_wren[d], ram_address[d], out_addr[d], out_data[d]);
      end
    end
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({busy[d], out_valid[d], done[d]} !== 3'b000) begin
        errors++;
        $display("FAIL idle_after_reset dut%0d: busy=%b valid=%b done=%b, want 000", d, busy[d], out_valid[d], done[d]);
      end
    end
  endtask

  // Drives one scan and checks every word, gap, hold and the done pulse
  // against the expected address list built by walking the range.
  task automatic run_scan(input int d, input int sa, input int ea, input bit cont,
                          input int n_words, input bit use_stop, input bit rand_ready,
                          input int hold_addr, input int hold_len, input bit poke_start,
                          input bit stop_with_start, input string tag);
    int exp_addr[$];
    int a, lows, hold, last, dw;
    logic [AW-1:0] ea_v;
    dw = dwell_of(d);
    a = sa;
    while (exp_addr.size() < n_words) begin
      exp_addr.push_back(a);
      if (a == ea) begin
        if (!cont) break;
        a = sa;
      end else begin
        a = (a + 1) % 32;
      end
    end
    last = exp_addr.size() - 1;

    start_addr[d] = AW'(sa); end_addr[d] = AW'(ea); continuous[d] = cont;
    start[d] = 1'b1; stop[d] = stop_with_start; out_ready[d] = 1'b0;
    tick();
    start[d] = 1'b0; stop[d] = 1'b0;
    start_addr[d] = AW'($urandom); end_addr[d] = AW'($urandom); continuous[d] = 1'($urandom);
    checks++;
    if (busy[d] !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start: busy=%b, want 1", tag, busy[d]);
    end

    for (int i = 0; i <= last; i++) begin
      lows = 0;
      while (!out_valid[d] && lows < 64) begin
        lows++;
        tick();
      end
      checks++;
      if (lows != ((i == 0) ? 2 : dw + 2)) begin
        errors++;
        $display("FAIL %s gap word%0d: %0d idle cycles, want %0d", tag, i, lows, (i == 0) ? 2 : dw + 2);
      end
      if (!out_valid[d]) return;
      ea_v = AW'(exp_addr[i]);
      checks++;
      if ({out_addr[d], out_data[d]} !== {ea_v, mem[exp_addr[i]]}) begin
        errors++;
        $display("FAIL %s word%0d: addr=%0d data=%0d, want addr=%0d data=%0d",
                 tag, i, out_addr[d], out_data[d], exp_addr[i], mem[exp_addr[i]]);
      end

      hold = (exp_addr[i] == hold_addr) ? hold_len : (rand_ready ? int'($urandom_range(0, 3)) : 0);
      if ((use_stop && i == last) || poke_start) hold = (hold < 1) ? 1 : hold;
      for (int h = 0; h < hold; h++) begin
        if (use_stop && i == last && h == 0) stop[d] = 1'b1;
        if (poke_start && h == 0) begin
          start[d] = 1'b1; start_addr[d] = AW'($urandom); end_addr[d] = AW'($urandom);
        end
        tick();
        stop[d] = 1'b0; start[d] = 1'b0;
        checks++;
        if ({out_valid[d], out_addr[d], out_data[d]} !== {1'b1, ea_v, mem[exp_addr[i]]}) begin
          errors++;
          $display("FAIL %s hold word%0d cyc%0d: valid=%b addr=%0d data=%0d, want 1/%0d/%0d",
                   tag, i, h, out_valid[d], out_addr[d], out_data[d], exp_addr[i], mem[exp_addr[i]]);
        end
      end
      out_ready[d] = 1'b1;
      tick();
      out_ready[d] = 1'b0;
      checks++;
      if (out_valid[d] !== 1'b0) begin
        errors++;
        $display("FAIL %s drop word%0d: valid=%b after handshake, want 0", tag, i, out_valid[d]);
      end
    end

    for (int k = 0; k <= dw; k++) begin
      checks++;
      if ({done[d], busy[d]} !== ((k == dw) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL %s finish k=%0d: done=%b busy=%b, want %b%b", tag, k, done[d], busy[d], k == dw, k != dw);
      end
      if (k < dw) tick();
    end
    tick();
    checks++;
    if ({done[d], busy[d], out_valid[d]} !== 3'b000) begin
      errors++;
      $display("FAIL %s after_done: done=%b busy=%b valid=%b, want 000", tag, done[d], busy[d], out_valid[d]);
    end
  endtask

  task automatic test_basic();
    for (int k = 0; k < 32; k++) mem[k] = DW'(k);
    run_scan(0, 0, 7, 1'b0, 64, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_backpressure();
    run_scan(0, 0, 7, 1'b0, 64, 1'b0, 1'b0, 3, 5, 1'b0, 1'b0, "backpressure");
  endtask

  task automatic test_wrap();
    run_scan(0, 30, 1, 1'b0, 64, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, "wrap0");
    run_scan(1, 30, 1, 1'b0, 64, 1'b0, 1'b1, -1, 0, 1'b0, 1'b0, "wrap4");
  endtask

  task automatic test_cont_stop();
    run_scan(0, 4, 5, 1'b1, 4, 1'b1, 1'b0, -1, 0, 1'b0, 1'b0, "cont_stop");
  endtask

  task automatic test_dwell();
    run_scan(1, 0, 7, 1'b0, 64, 1'b0, 1'b1, -1, 0, 1'b1, 1'b0, "dwell");
  endtask

  task automatic test_random();
    int d, sa, ea, n;
    bit cont;
    for (int k = 0; k < 32; k++) mem[k] = DW'($urandom);
    for (int t = 0; t < 8; t++) begin
      d    = int'($urandom_range(0, 1));
      sa   = int'($urandom_range(0, 31));
      ea   = (sa + int'($urandom_range(0, 9))) % 32;
      cont = 1'($urandom);
      n    = int'($urandom_range(1, 20));
      run_scan(d, sa, ea, cont, cont ? n : 64, cont, 1'b1, -1, 0, 1'($urandom), 1'($urandom), "random");
    end
  endtask

  task automatic test_reset_mid();
    int waited;
    for (int d = 0; d < 2; d++) begin
      start_addr[d] = AW'(2); end_addr[d] = AW'(9); continuous[d] = 1'b1;
      start[d] = 1'b1; out_ready[d] = 1'b0;
    end
    tick();
    start = '0;
    waited = 0;
    while (!(out_valid[0] && out_valid[1]) && waited < 32) begin
      waited++;
      tick();
    end
    #3;
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({out_valid[d], busy[d], done[d], ram_wren[d]} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_mid dut%0d: valid=%b busy=%b done=%b wren=%b, want 0000",
                 d, out_valid[d], busy[d], done[d], ram_wren[d]);
      end
    end
    @(negedge clock);
    reset_n = 1'b1;
    stop = 2'b11;
    for (int c = 0; c < 4; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({out_valid[d], busy[d], done[d]} !== 3'b000) begin
          errors++;
          $display("FAIL post_reset_idle dut%0d cyc%0d: valid=%b busy=%b done=%b, want 000",
                   d, c, out_valid[d], busy[d], done[d]);
        end
      end
    end
    stop = '0;
    run_scan(0, 9, 9, 1'b0, 64, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, "single0");
    run_scan(1, 9, 9, 1'b0, 64, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, "single4");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_cont_stop();
    test_dwell();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
